// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: arbitrates cache miss requesters and streams one aligned line
// from a fixed-latency pipelined memory back to the granted port.
module cache_fill_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int MEM_LATENCY    = 4,
    parameter int RR_MODE        = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
    output logic [NUM_PORTS-1:0]              grant,
    output logic                              busy,
    output logic                              mem_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              fill_valid,
    output logic [DATA_W-1:0]                 fill_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word_idx,
    output logic                              fill_done
);
    localparam int IW = $clog2(WORDS_PER_LINE);
    localparam int PW = $clog2(NUM_PORTS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(2 * WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       win_q, win_d, rr_q, rr_d, pick;
    logic [ADDR_W-1:0]   base_q, base_d, sel_addr;
    logic [IW-1:0]       issue_q, issue_d;
    logic [IW:0]         rcv_q, rcv_d;
    logic [MEM_LATENCY-1:0] dl_v_q, dl_v_d;
    logic [IW-1:0]       dl_i_q [MEM_LATENCY];
    logic [IW-1:0]       dl_i_d [MEM_LATENCY];

    // descending scan so the first hit in priority order is the last assignment
    always_comb begin
        int j;
        j = 0;
        pick = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = (RR_MODE != 0) ? (int'(rr_q) + k) % NUM_PORTS : k;
            if (req[PW'(j)]) pick = PW'(j);
        end
        sel_addr = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            if (pick == PW'(k)) sel_addr = req_addr[k*ADDR_W +: ADDR_W];
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rr_d    = rr_q;
        base_d  = base_q;
        issue_d = issue_q;
        rcv_d   = (state_q == IDLE) ? '0 : rcv_q + (IW+1)'(fill_valid);
        case (state_q)
            IDLE: if (|req) begin
                state_d = ISSUE;
                win_d   = pick;
                base_d  = sel_addr & ~LINE_MASK;
            end
            ISSUE: begin
                issue_d = issue_q + 1'b1;
                if (issue_q == IW'(WORDS_PER_LINE - 1)) state_d = DRAIN;
            end
            DRAIN: if (rcv_d == (IW+1)'(WORDS_PER_LINE)) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                rr_d    = (win_q == PW'(NUM_PORTS - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dl_v_d[0] = mem_en;
        dl_i_d[0] = issue_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            dl_v_d[i] = dl_v_q[i-1];
            dl_i_d[i] = dl_i_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            rr_q    <= '0;
            base_q  <= '0;
            issue_q <= '0;
            rcv_q   <= '0;
            dl_v_q  <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) dl_i_q[i] <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            rcv_q   <= rcv_d;
            dl_v_q  <= dl_v_d;
            for (int i = 0; i < MEM_LATENCY; i++) dl_i_q[i] <= dl_i_d[i];
        end
    end

    assign busy          = state_q != IDLE;
    assign grant         = busy ? NUM_PORTS'(1) << win_q : '0;
    assign mem_en        = state_q == ISSUE;
    // base has the line offset cleared, so OR-ing the offset never carries out of the line
    assign mem_addr      = mem_en ? base_q | ADDR_W'({issue_q, 1'b0}) : '0;
    assign fill_valid    = dl_v_q[MEM_LATENCY-1];
    assign fill_word_idx = fill_valid ? dl_i_q[MEM_LATENCY-1] : '0;
    assign fill_data     = fill_valid ? mem_rdata : '0;
    assign fill_done     = state_q == DONE;
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: cycle tables, hand sequences and a beat scoreboard for two builds
// (dut0: defaults, fixed priority; dut1: 4-word lines, latency 1, round robin).
module tb_cache_fill_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req [2];
    logic [31:0] addr [2];
    logic [1:0]  grant [2];
    logic        busy [2];
    logic        mem_en [2];
    logic        fv [2];
    logic        fd [2];
    logic [15:0] maddr [2];
    logic [15:0] mrd [2];
    logic [15:0] fdat [2];
    logic [2:0]  fwi0;
    logic [1:0]  fwi1;

    cache_fill_arbiter #(.RR_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .req_addr(addr[0]), .grant(grant[0]),
        .busy(busy[0]), .mem_en(mem_en[0]), .mem_addr(maddr[0]), .mem_rdata(mrd[0]),
        .fill_valid(fv[0]), .fill_data(fdat[0]), .fill_word_idx(fwi0), .fill_done(fd[0]));

    cache_fill_arbiter #(.WORDS_PER_LINE(4), .MEM_LATENCY(1), .RR_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .req_addr(addr[1]), .grant(grant[1]),
        .busy(busy[1]), .mem_en(mem_en[1]), .mem_addr(maddr[1]), .mem_rdata(mrd[1]),
        .fill_valid(fv[1]), .fill_data(fdat[1]), .fill_word_idx(fwi1), .fill_done(fd[1]));

    // memory models: word at address a reads as a ^ 16'h5A5A, ignoring reset
    logic [15:0] mp0 [4];
    logic [15:0] mp1;
    always @(posedge clk) begin
        mp0[0] <= mem_en[0] ? maddr[0] ^ 16'h5A5A : 16'hDEAD;
        for (int i = 1; i < 4; i++) mp0[i] <= mp0[i-1];
        mp1 <= mem_en[1] ? maddr[1] ^ 16'h5A5A : 16'hDEAD;
    end
    assign mrd[0] = mp0[3];
    assign mrd[1] = mp1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nb0 = 0;

    typedef struct {int idx; int data;} beat_t;
    beat_t sb0[$];
    beat_t sb1[$];
    beat_t e0, e1;

    task automatic chk(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic push_fill(int s, int a, int wpl);
        beat_t e;
        int b;
        b = a & ~(2 * wpl - 1);
        for (int w = 0; w < wpl; w++) begin
            e.idx  = w;
            e.data = ((b + 2 * w) ^ 'h5A5A) & 'hFFFF;
            if (s == 0) sb0.push_back(e);
            else sb1.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (fv[0]) begin
            nb0++;
            if (sb0.size() == 0) chk("beat0_extra", 1, 0);
            else begin
                e0 = sb0.pop_front();
                chk("beat0_idx", int'(fwi0), e0.idx);
                chk("beat0_data", int'(fdat[0]), e0.data);
            end
        end
        if (fv[1]) begin
            if (sb1.size() == 0) chk("beat1_extra", 1, 0);
            else begin
                e1 = sb1.pop_front();
                chk("beat1_idx", int'(fwi1), e1.idx);
                chk("beat1_data", int'(fdat[1]), e1.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req[0] = '0;
        req[1] = '0;
        tick();
        tick();
        rst = 1'b0;
        sb0.delete();
        sb1.delete();
        cyc = 0;
    endtask

    task automatic wait_done(int s, int bound);
        int n;
        n = 0;
        while (!(s == 1 ? fd[1] : fd[0]) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_busy(int s, int bound);
        int n;
        n = 0;
        while (!(s == 1 ? busy[1] : busy[0]) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk("busy_timeout", 0, 1);
    endtask

    typedef struct {int g; int en; int ma; int v; int wi; int dn;} vec_t;
    vec_t tv [16];

    initial begin
        int n0;
        req[0] = '0;
        req[1] = '0;
        addr[0] = '0;
        addr[1] = '0;
        for (int c = 0; c < 16; c++) begin
            tv[c].g  = (c >= 1 && c <= 13) ? 2 : 0;
            tv[c].en = (c >= 1 && c <= 8) ? 1 : 0;
            tv[c].ma = 'h1230 + 2 * (c - 1);
            tv[c].v  = (c >= 5 && c <= 12) ? 1 : 0;
            tv[c].wi = c - 5;
            tv[c].dn = (c == 13) ? 1 : 0;
        end

        do_reset();
        chk("rst_grant0", int'(grant[0]), 0);
        chk("rst_busy0", int'(busy[0]), 0);
        chk("rst_memen0", int'(mem_en[0]), 0);
        chk("rst_fv0", int'(fv[0]), 0);
        chk("rst_done0", int'(fd[0]), 0);
        chk("rst_grant1", int'(grant[1]), 0);
        chk("rst_busy1", int'(busy[1]), 0);

        // single port-1 fill, cycle by cycle
        req[0] = 2'b10;
        addr[0] = {16'h1236, 16'h0000};
        push_fill(0, 'h1236, 8);
        for (int c = 0; c < 16; c++) begin
            chk("t1_grant", int'(grant[0]), tv[c].g);
            chk("t1_mem_en", int'(mem_en[0]), tv[c].en);
            if (tv[c].en != 0) chk("t1_mem_addr", int'(maddr[0]), tv[c].ma);
            chk("t1_fill_valid", int'(fv[0]), tv[c].v);
            if (tv[c].v != 0) chk("t1_word_idx", int'(fwi0), tv[c].wi);
            chk("t1_fill_done", int'(fd[0]), tv[c].dn);
            if (c == 13) req[0] = '0;
            tick();
        end

        // fixed priority with both ports pending
        do_reset();
        req[0] = 2'b11;
        addr[0] = {16'h2000, 16'h0040};
        push_fill(0, 'h0040, 8);
        push_fill(0, 'h2000, 8);
        go(1);
        chk("t2_grant_p0", int'(grant[0]), 1);
        chk("t2_addr_first", int'(maddr[0]), 'h0040);
        go(8);
        chk("t2_addr_last", int'(maddr[0]), 'h004E);
        go(13);
        chk("t2_done", int'(fd[0]), 1);
        chk("t2_grant_in_done", int'(grant[0]), 1);
        req[0] = 2'b10;
        go(14);
        chk("t2_idle_busy", int'(busy[0]), 0);
        chk("t2_idle_grant", int'(grant[0]), 0);
        go(15);
        chk("t2_grant_p1", int'(grant[0]), 2);
        chk("t2_addr_p1", int'(maddr[0]), 'h2000);
        wait_done(0, 40);
        req[0] = '0;
        tick();

        // granted port drops req mid-fill; pending port follows
        do_reset();
        req[0] = 2'b11;
        addr[0] = {16'h0300, 16'h0100};
        push_fill(0, 'h0100, 8);
        push_fill(0, 'h0300, 8);
        n0 = nb0;
        go(3);
        req[0] = 2'b10;
        go(13);
        chk("t5_done", int'(fd[0]), 1);
        chk("t5_beats", nb0 - n0, 8);
        go(15);
        chk("t5_grant_p1", int'(grant[0]), 2);
        wait_done(0, 40);
        req[0] = '0;
        tick();

        // reset in the middle of a fill
        do_reset();
        req[0] = 2'b01;
        addr[0] = {16'h0000, 16'h0500};
        push_fill(0, 'h0500, 8);
        go(7);
        rst = 1'b1;
        req[0] = '0;
        tick();
        chk("t4_grant", int'(grant[0]), 0);
        chk("t4_busy", int'(busy[0]), 0);
        chk("t4_mem_en", int'(mem_en[0]), 0);
        rst = 1'b0;
        sb0.delete();
        for (int c = 8; c <= 13; c++) begin
            chk("t4_no_valid", int'(fv[0]), 0);
            chk("t4_no_done", int'(fd[0]), 0);
            tick();
        end
        req[0] = 2'b01;
        addr[0] = {16'h0000, 16'h0600};
        push_fill(0, 'h0600, 8);
        cyc = 0;
        go(1);
        chk("t4_regrant", int'(grant[0]), 1);
        chk("t4_readdr", int'(maddr[0]), 'h0600);
        wait_done(0, 40);
        chk("t4_done_cycle", cyc, 13);
        req[0] = '0;
        tick();

        // top-of-memory line, no wrap (8 words, latency 4)
        do_reset();
        req[0] = 2'b01;
        addr[0] = {16'h0000, 16'hFFFE};
        push_fill(0, 'hFFFE, 8);
        go(1);
        chk("t6_addr_first", int'(maddr[0]), 'hFFF0);
        go(8);
        chk("t6_addr_last", int'(maddr[0]), 'hFFFE);
        go(9);
        chk("t6_issue_end", int'(mem_en[0]), 0);
        wait_done(0, 40);
        chk("t6_done_cycle", cyc, 13);
        req[0] = '0;
        tick();

        // same on the 4-word, latency-1 build
        do_reset();
        req[1] = 2'b01;
        addr[1] = {16'h0000, 16'hFFFE};
        push_fill(1, 'hFFFE, 4);
        go(1);
        chk("t6b_addr_first", int'(maddr[1]), 'hFFF8);
        go(4);
        chk("t6b_addr_last", int'(maddr[1]), 'hFFFE);
        go(5);
        chk("t6b_no_done", int'(fd[1]), 0);
        go(6);
        chk("t6b_done", int'(fd[1]), 1);
        req[1] = '0;
        tick();

        // four back-to-back fills with both ports held: round robin vs fixed priority
        do_reset();
        req[1] = 2'b11;
        addr[1] = {16'h3000, 16'h0800};
        for (int f = 0; f < 4; f++) begin
            wait_busy(1, 20);
            chk("t3_rr_grant", int'(grant[1]), (f % 2 == 1) ? 2 : 1);
            push_fill(1, (f % 2 == 1) ? 'h3000 : 'h0800, 4);
            wait_done(1, 40);
            if (f == 3) req[1] = '0;
            tick();
        end
        req[0] = 2'b11;
        addr[0] = {16'h3000, 16'h0800};
        for (int f = 0; f < 4; f++) begin
            wait_busy(0, 20);
            chk("t3_fixed_grant", int'(grant[0]), 1);
            push_fill(0, 'h0800, 8);
            wait_done(0, 40);
            if (f == 3) req[0] = '0;
            tick();
        end
        tick();
        tick();
        chk("sb0_left", sb0.size(), 0);
        chk("sb1_left", sb1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Parametrised miss-handling engine shared by the instruction and data caches. It replaces the fixed two-cache, single-mode fill path.
- Arbitrates among NUM_PORTS cache miss requesters. Supports fixed-priority or round-robin selection.
- Streams one aligned cache line from a fixed-latency pipelined memory and returns the words to the granted port with word index and completion pulse.
- Sits between the cache controllers and main memory.

Parameters:
- NUM_PORTS, 2, number of requesting caches (port 0 = I-cache, port 1 = D-cache by convention).
- ADDR_W, 16, byte address width.
- DATA_W, 16, memory word width; words are 2 bytes.
- WORDS_PER_LINE, 8, words per line; power of two, ≥2.
- MEM_LATENCY, 4, cycles from mem_en to mem_rdata valid; ≥1.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_PORTS  per-port miss request, held until fill_done for that port.
- req_addr  in  NUM_PORTS*ADDR_W  per-port miss byte address; port i occupies bits [i*ADDR_W +: ADDR_W].
- grant  out  NUM_PORTS  one-hot owner of the current fill; zero when idle.
- busy  out  1  fill in progress (state != IDLE).
- mem_en  out  1  memory read issue strobe.
- mem_addr  out  ADDR_W  memory read byte address.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en.
- fill_valid  out  1  fill_data valid this cycle.
- fill_data  out  DATA_W  returned word; equals mem_rdata when fill_valid is high.
- fill_word_idx  out  log2(WORDS_PER_LINE)  index of the returned word within the line.
- fill_done  out  1  one-cycle pulse, line complete for the port in grant.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, RR pointer 0, delay line cleared, counters 0.
- Reset mid-fill: in-flight returns are discarded; no fill_valid or fill_done is produced afterwards.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If any req bit is set, select a winner.
  - RR_MODE=0: the lowest set index wins.
  - RR_MODE=1: the first set index at or after the RR pointer wins, wrapping around.
  - Register one-hot grant and base = req_addr[winner] with low log2(WORDS_PER_LINE)+1 bits cleared. Go to ISSUE.
  - If no req bit is set: stay in IDLE, grant=0.
- ISSUE:
  - mem_en=1, mem_addr = base + 2*issue_cnt, issue_cnt++.
  - Runs exactly WORDS_PER_LINE consecutive cycles, then goes to DRAIN.
  - The address add never carries out of the line; no wrap beyond base.
- Return path:
  - A MEM_LATENCY-deep delay line of {valid, word_idx} is pushed each cycle with {mem_en, issue_cnt}.
  - Its output drives fill_valid and fill_word_idx; fill_data = mem_rdata.
  - Words return in order, one per cycle, with no gaps.
- DRAIN: wait until rcv_cnt == WORDS_PER_LINE, then go to DONE. ISSUE and DRAIN overlap the return window.
- DONE:
  - fill_done=1 for one cycle; grant stays asserted during DONE.
  - RR pointer becomes (winner+1) mod NUM_PORTS. Go to IDLE; grant clears.
- Latency, with req sampled in IDLE at cycle T:
  - grant and first mem_en at T+1; last mem_en at T+WORDS_PER_LINE.
  - First fill_valid at T+1+MEM_LATENCY; last at T+WORDS_PER_LINE+MEM_LATENCY.
  - fill_done at T+WORDS_PER_LINE+MEM_LATENCY+1.
  - Minimum gap between fills: one IDLE cycle.
- Request handling during a fill:
  - No abort. If the granted req deasserts mid-fill, the fill still completes with all words and fill_done.
  - Requests arriving during a fill wait; the grant does not change until IDLE.
- Simultaneous requests in IDLE: exactly one grant; all others remain pending.
- req_addr is sampled only in IDLE; later changes do not affect the current fill.

Test Plan:
1. Defaults; req=2'b10, req_addr[1]=0x1236 at cycle 0 -> grant=2'b10 at cycle 1; mem_addr 0x1230,0x1232,…,0x123E on cycles 1–8; fill_valid cycles 5–12 with fill_word_idx 0–7 and data matching the memory model; fill_done at cycle 13 only.
2. RR_MODE=0; req=2'b11 held, port0 addr 0x0040, port1 addr 0x2000 -> port0 filled first (mem_addr 0x0040–0x004E); fill_done cycle 13; IDLE cycle 14; grant=2'b10 cycle 15 with mem_addr 0x2000.
3. RR_MODE=1; both ports held continuously for 4 fills -> grant sequence 01,10,01,10; fixed-priority build gives 01,01,01,01.
4. rst asserted at cycle 7 of a fill (during ISSUE/return overlap) -> cycle 8: grant=0, busy=0, mem_en=0; no fill_valid on cycles 8–13 despite the memory model returning data; a new req starts a clean fill.
5. Port 0 drops req at cycle 3 of its fill -> all 8 fill_valid beats and fill_done still occur; then port 1 is granted if pending.
6. req_addr=0xFFFE, WORDS_PER_LINE=8 -> base 0xFFF0, mem_addr 0xFFF0–0xFFFE, no address wrap; repeat with WORDS_PER_LINE=4, MEM_LATENCY=1 -> fill_done at cycle 6.
